// File: rtl/instr_parcel_issue_if.sv
// Instruction word / decoded-instruction handshake bundle
// between the instruction buffers, the parcel splitter and issue.
interface instr_parcel_issue_if #(
  parameter int PADDR_W = 22
);
  logic               i_word_valid;
  logic [63:0]        i_word;
  logic               o_word_ready;
  logic               i_flush;
  logic [PADDR_W-1:0] i_flush_paddr;
  logic               o_valid;
  logic               i_issue;
  logic [6:0]         o_instr;
  logic [2:0]         o_cip_i;
  logic [2:0]         o_cip_j;
  logic [2:0]         o_cip_k;
  logic [15:0]        o_lip;
  logic               o_two_parcel;
  logic [PADDR_W-1:0] o_paddr;

  modport master (
    output i_word_valid, i_word, i_flush,
    output i_flush_paddr, i_issue,
    input  o_word_ready, o_valid, o_instr,
    input  o_cip_i, o_cip_j, o_cip_k,
    input  o_lip, o_two_parcel, o_paddr
  );

  modport slave (
    input  i_word_valid, i_word, i_flush,
    input  i_flush_paddr, i_issue,
    output o_word_ready, o_valid, o_instr,
    output o_cip_i, o_cip_j, o_cip_k,
    output o_lip, o_two_parcel, o_paddr
  );
endinterface

// File: rtl/instr_parcel_issue.sv
// Splits 64-bit instruction words into 1/2-parcel instructions,
// reassembling 2-parcel instructions that straddle a word boundary.
module instr_parcel_issue #(
  parameter int PADDR_W = 22
) (
  input logic                 clk,
  input logic                 rst,
  instr_parcel_issue_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY,
    RUN,
    SPLIT
  } state_t;

  state_t             state;
  logic [63:0]        cur_word;
  logic               buf_valid;
  logic [1:0]         ptr;
  logic [15:0]        saved;
  logic [PADDR_W-1:0] pc;

  logic               valid_q;
  logic [6:0]         instr_q;
  logic [2:0]         i_q;
  logic [2:0]         j_q;
  logic [2:0]         k_q;
  logic [15:0]        lip_q;
  logic               two_q;
  logic [PADDR_W-1:0] paddr_q;

  logic [1:0]  nxt_ptr;
  logic [15:0] cur_p;
  logic [15:0] nxt_p;
  logic [15:0] e_p;
  logic [15:0] e_lip;
  logic        e_two;
  logic        cur_two;
  logic        adv;
  logic        split_go;
  logic        leave;
  logic        emit;
  logic        ready;
  logic        accept;

  // gh 006,007,010-017,020,021,040,041,100-137
  function automatic logic two_op(
    input logic [6:0] gh
  );
    return gh[6:5] == 2'b10
      || gh[6:3] == 4'b0001
      || gh[6:1] == 6'b000011
      || gh[6:1] == 6'b001000
      || gh[6:1] == 6'b010000;
  endfunction

  assign nxt_ptr  = ptr + 2'd1;
  assign cur_p    = cur_word[{~ptr, 4'h0} +: 16];
  assign nxt_p    = cur_word[{~nxt_ptr, 4'h0} +: 16];
  assign cur_two  = two_op(cur_p[15:9]);
  assign adv      = !valid_q || bus.i_issue;
  assign split_go = state == RUN && cur_two
                 && ptr == 2'd3;
  assign leave    = state == RUN && adv
                 && (ptr == 2'd3
                 || (cur_two && ptr == 2'd2));
  assign emit     = adv
                 && ((state == RUN && !split_go)
                 || (state == SPLIT && buf_valid));
  assign ready    = !rst && !bus.i_flush
                 && (state == EMPTY || leave
                 || (state == SPLIT && !buf_valid));
  assign accept   = bus.i_word_valid && ready;

  always_comb begin
    e_p   = cur_p;
    e_lip = cur_two ? nxt_p : 16'h0;
    e_two = cur_two;
    if (state == SPLIT) begin
      e_p   = saved;
      e_lip = cur_word[63:48];
      e_two = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      cur_word  <= '0;
      buf_valid <= 1'b0;
      ptr       <= 2'd0;
      saved     <= '0;
      pc        <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      lip_q     <= '0;
      two_q     <= 1'b0;
      paddr_q   <= '0;
    end else if (bus.i_flush) begin
      state     <= EMPTY;
      buf_valid <= 1'b0;
      valid_q   <= 1'b0;
      ptr       <= bus.i_flush_paddr[1:0];
      pc        <= bus.i_flush_paddr;
    end else begin
      if (accept) begin
        cur_word  <= bus.i_word;
        buf_valid <= 1'b1;
      end
      if (adv)
        valid_q <= emit;
      if (emit) begin
        instr_q <= e_p[15:9];
        i_q     <= e_p[8:6];
        j_q     <= e_p[5:3];
        k_q     <= e_p[2:0];
        lip_q   <= e_lip;
        two_q   <= e_two;
        paddr_q <= pc;
        pc      <= pc + (e_two ? PADDR_W'(2)
                               : PADDR_W'(1));
        ptr     <= (state == SPLIT) ? 2'd1
                 : ptr + (cur_two ? 2'd2 : 2'd1);
      end
      unique case (state)
        EMPTY: if (accept) state <= RUN;
        RUN: if (adv) begin
          // the upper half waits here for m
          if (split_go) begin
            saved <= cur_p;
            state <= SPLIT;
          end else if (leave && !accept) begin
            state <= EMPTY;
          end
          if (leave && !accept)
            buf_valid <= 1'b0;
        end
        SPLIT: if (emit) state <= RUN;
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.o_word_ready = ready;
  assign bus.o_valid      = valid_q;
  assign bus.o_instr      = instr_q;
  assign bus.o_cip_i      = i_q;
  assign bus.o_cip_j      = j_q;
  assign bus.o_cip_k      = k_q;
  assign bus.o_lip        = lip_q;
  assign bus.o_two_parcel = two_q;
  assign bus.o_paddr      = paddr_q;
endmodule
